// File: rtl/servant_pkg.sv
// Shared definitions for the servant sleep controller: FSM encoding and
// wake-source bit placement.
package servant_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SLEEP = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  // Offset of the explicit-wake bit above the IRQ bits in o_wake_src.
  localparam int unsigned WAKE_SRC_EXT = 0;

  function automatic int unsigned wake_src_ext_idx(input int unsigned num_irq);
    return num_irq + WAKE_SRC_EXT;
  endfunction

  function automatic logic state_clk_en(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/servant_clkgate.sv
// Latch-based glitch-free clock gate: enable captured while i_clk is low,
// so o_gclk only ever produces full high phases.
module servant_clkgate (
  input  logic i_clk,
  input  logic i_en,
  output logic o_gclk
);

  logic en_lat;

  always_latch begin
    if (!i_clk) en_lat <= i_en;
  end

  assign o_gclk = i_clk & en_lat;

endmodule

// File: rtl/servant_sleep_ctrl.sv
// Core sleep controller: RUN/DRAIN/SLEEP/WAKE sequencing, wake-cause capture,
// sleep-cycle counting and registered core-clock enable.
module servant_sleep_ctrl
  import servant_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 1,
  parameter int unsigned WAKE_DELAY = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DRAIN_EN   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sleep_req,
  input  logic               i_wakeup_req,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_bus_idle,
  output logic               o_gclk,
  output logic               o_clk_en,
  output logic               o_sleep,
  output logic [NUM_IRQ:0]   o_wake_src,
  output logic [CNT_W-1:0]   o_sleep_cycles
);

  localparam int unsigned EXT_IDX  = wake_src_ext_idx(NUM_IRQ);
  localparam logic [7:0]  DLY_LAST = (WAKE_DELAY == 0) ? 8'd0 : 8'(WAKE_DELAY - 1);

  logic [1:0]         state_q, state_d;
  logic [7:0]         delay_q, delay_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IRQ:0]   src_q, src_d;
  logic               clk_en_q;
  logic               wake;
  logic [NUM_IRQ:0]   wake_cause;
  logic               enter_sleep;
  logic               latch_src;

  always_comb begin
    wake_cause                = '0;
    wake_cause[NUM_IRQ-1:0]   = i_irq & i_irq_mask;
    wake_cause[EXT_IDX]       = i_wakeup_req;
  end

  assign wake = |wake_cause;

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    enter_sleep = 1'b0;
    latch_src   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_sleep_req && !wake) begin
          if (DRAIN_EN != 0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d     = ST_SLEEP;
            enter_sleep = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (wake) begin
          state_d = ST_RUN;
        end else if (i_bus_idle) begin
          state_d     = ST_SLEEP;
          enter_sleep = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (wake) begin
          latch_src = 1'b1;
          delay_d   = '0;
          state_d   = (WAKE_DELAY == 0) ? ST_RUN : ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (delay_q == DLY_LAST) begin
          state_d = ST_RUN;
          delay_d = '0;
        end else begin
          delay_d = delay_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The exit edge out of SLEEP still counts, so the count equals cycles spent in SLEEP.
  always_comb begin
    cnt_d = cnt_q;
    src_d = src_q;
    if (enter_sleep) begin
      cnt_d = '0;
      src_d = '0;
    end else if (state_q == ST_SLEEP) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (latch_src) src_d = wake_cause;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      delay_q  <= '0;
      cnt_q    <= '0;
      src_q    <= '0;
      clk_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      clk_en_q <= state_clk_en(state_q);
    end
  end

  servant_clkgate u_clkgate (
    .i_clk  (i_clk),
    .i_en   (clk_en_q),
    .o_gclk (o_gclk)
  );

  assign o_clk_en       = clk_en_q;
  assign o_sleep        = (state_q == ST_SLEEP) || (state_q == ST_WAKE);
  assign o_wake_src     = src_q;
  assign o_sleep_cycles = cnt_q;

endmodule

// File: doc/servant_sleep_ctrl.md
SERVANT_SLEEP_CTRL -- requirements
Module: servant_sleep_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 1: number of interrupt wake sources, range 1..32.
REQ-002 SHALL have parameter WAKE_DELAY, default 4: cycles held in WAKE before the clock re-enables, range 0..255.
REQ-003 SHALL have parameter CNT_W, default 32: sleep-cycle counter width, range 8..64.
REQ-004 SHALL have parameter DRAIN_EN, default 1: 1 waits for bus idle before sleeping; 0 skips DRAIN.
REQ-005 SHALL have port i_clk  in  1  clock, free-running, never gated.
REQ-006 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_sleep_req  in  1  CPU sleep request (WFI), level, sampled each cycle.
REQ-008 SHALL have port i_wakeup_req  in  1  explicit wake request, e.g. timer.
REQ-009 SHALL have port i_irq  in  NUM_IRQ  level interrupt sources.
REQ-010 SHALL have port i_irq_mask  in  NUM_IRQ  1 = source may wake.
REQ-011 SHALL have port i_bus_idle  in  1  1 = no Wishbone cycle outstanding.
REQ-012 SHALL have port o_gclk  out  1  glitch-free gated core clock.
REQ-013 SHALL have port o_clk_en  out  1  registered enable feeding the gate.
REQ-014 SHALL have port o_sleep  out  1  1 while state is SLEEP or WAKE.
REQ-015 SHALL have port o_wake_src  out  NUM_IRQ+1  latched wake cause; bit NUM_IRQ = i_wakeup_req.
REQ-016 SHALL have port o_sleep_cycles  out  CNT_W  cycles spent in the last or current SLEEP.

Function
REQ-017 SHALL define wake event: wake = i_wakeup_req | OR-reduce(i_irq & i_irq_mask).
REQ-018 SHALL implement FSM states RUN, DRAIN, SLEEP, WAKE; o_clk_en = 1 only in RUN and DRAIN.
REQ-019 RUN: on i_sleep_req & !wake SHALL go to DRAIN (DRAIN_EN=1) or SLEEP (DRAIN_EN=0); sleep_req & wake together SHALL stay in RUN.
REQ-020 DRAIN: wake SHALL abort to RUN (wake wins); else i_bus_idle SHALL go to SLEEP; else stay.
REQ-021 SLEEP entry SHALL clear o_sleep_cycles to 0 and o_wake_src to 0 on the same edge.
REQ-022 SLEEP: counter SHALL increment by 1 per cycle, saturating at all-ones without wrapping.
REQ-023 SLEEP: wake SHALL latch cause bits into o_wake_src and go to WAKE, or to RUN when WAKE_DELAY=0.
REQ-024 WAKE SHALL last exactly WAKE_DELAY cycles, then go to RUN; o_sleep_cycles SHALL not count in WAKE and SHALL hold until next SLEEP entry.
REQ-025 i_sleep_req in SLEEP/WAKE SHALL be ignored; wake in WAKE SHALL be ignored, causes not re-latched.
REQ-026 o_clk_en SHALL be a flop output; the core-clock stop/start latency SHALL be 1 i_clk edge after the state change.
REQ-027 o_gclk SHALL change only while i_clk is low-to-high aligned, with no runt pulses, for any o_clk_en timing.

Reset
REQ-028 i_rst SHALL force state RUN, o_clk_en=1, o_sleep=0, o_wake_src=0, o_sleep_cycles=0, delay counter 0.
REQ-029 Reset in any state, including mid-SLEEP or mid-WAKE, SHALL restore o_clk_en=1 on the next edge.
REQ-030 o_gclk SHALL keep toggling during reset.

Structure
REQ-031 State encoding and WAKE_SRC_EXT index constant SHALL reside in shared package servant_pkg.
REQ-032 Gating SHALL be sub-module servant_clkgate: latch transparent while i_clk low, o_gclk = i_clk & latched enable.
REQ-033 All other logic SHALL be single-clock on i_clk posedge.

Verification
REQ-034 DRAIN_EN=1, i_bus_idle=0 for 5 cycles after i_sleep_req, then 1 -> DRAIN 5 cycles, SLEEP next, o_clk_en=0 one edge later.
REQ-035 NUM_IRQ=4, mask=4'b0100, i_irq=4'b0010 pulses in SLEEP -> no wake; i_irq=4'b0100 after 100 SLEEP cycles -> o_wake_src=5'b00100, o_sleep_cycles=100, o_clk_en=1 after exactly WAKE_DELAY=4 cycles.
REQ-036 CNT_W=8, SLEEP held 300 cycles -> o_sleep_cycles=255 saturated; then i_wakeup_req -> o_wake_src=5'b10000.
REQ-037 i_sleep_req and i_wakeup_req both 1 in RUN -> stays RUN, o_clk_en stays 1; wake during DRAIN -> RUN next cycle.
REQ-038 i_rst asserted at WAKE cycle 2 -> RUN, o_clk_en=1, all outputs 0 next edge; WAKE_DELAY=0 -> SLEEP->RUN in 1 cycle.
REQ-039 Random o_clk_en toggling -> o_gclk high pulses always full i_clk high-phase width (assertion).
